// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, single-entry output register, redirect squash, fault halt.
// Optional macro IFETCH_PERF_CNT_EN adds saturating fetch_count/stall_count outputs.
module instr_fetch_ctrl #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] opc_q, opc_d;
    logic        fault_q, fault_d;
    logic        fetch;
    logic        fetch_opp;
    logic        pc_legal;
    logic [64:0] pc_last_byte;

    // 65-bit sum so an address near the top of the 64-bit space cannot wrap into range
    assign pc_last_byte = {1'b0, pc_q} + 65'd3;
    assign pc_legal     = (pc_q[1:0] == 2'b00) && (pc_last_byte < 65'(MEM_SIZE));
    assign fetch_opp    = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        fault_d = fault_q;
        fetch   = 1'b0;

        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = RUN;
            fault_d = 1'b0;
        end else begin
            if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
            if (state_q == RUN && fetch_opp) begin
                if (pc_legal) begin
                    fetch = 1'b1;
                end else begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end
            end
        end

        if (fetch) begin
            instr_d = imem_instr;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            opc_q   <= 64'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign fault     = fault_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (fetch && fetch_cnt_q != 32'hFFFF_FFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (valid_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a combinational ROM whose word is a fixed function of the address.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    instr_fetch_ctrl #(
        .MEM_SIZE(1024),
        .RESET_PC(64'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .fault      (fault)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    function automatic logic [31:0] rom(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = rom(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [63:0] pc);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".instr"}, 64'(out_instr), 64'(rom(pc)));
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        out_ready   = 1'b1;
        #2;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.pc", out_pc, 64'd0);
        check("rst.instr", 64'(out_instr), 64'd0);
        check("rst.fault", 64'(fault), 64'd0);
        check("rst.addr", imem_addr, 64'd0);
        step();
        step();
        reset = 1'b0;

        // boot cycle, then sequential fetch
        step();
        check("boot.valid", 64'(out_valid), 64'd0);
        check("boot.addr", imem_addr, 64'd0);
        step(); chk_out("seq0", 64'h0);
        check("seq0.addr", imem_addr, 64'h4);
        step(); chk_out("seq4", 64'h4);
        step(); chk_out("seq8", 64'h8);

        // stall while 8 is presented
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 64'h8);
            check("stall.addr", imem_addr, 64'hC);
        end
        out_ready = 1'b1;
        step(); chk_out("unstall", 64'hC);
        step(); chk_out("seq10", 64'h10);

        // redirect with one bubble
        redirect = 1'b1; redirect_pc = 64'h40;
        step();
        check("redir.bubble", 64'(out_valid), 64'd0);
        check("redir.addr", imem_addr, 64'h40);
        redirect = 1'b0;
        step(); chk_out("redir.tgt", 64'h40);

        // run off the end of the ROM
        redirect = 1'b1; redirect_pc = 64'h3F0;
        step();
        redirect = 1'b0;
        step(); chk_out("end0", 64'h3F0);
        step(); chk_out("end4", 64'h3F4);
        step(); chk_out("end8", 64'h3F8);
        step(); chk_out("endC", 64'h3FC);
        check("endC.fault", 64'(fault), 64'd0);
        out_ready = 1'b0;
        step(); chk_out("end.hold", 64'h3FC);
        check("end.hold.fault", 64'(fault), 64'd0);
        out_ready = 1'b1;
        step();
        check("oob.fault", 64'(fault), 64'd1);
        check("oob.valid", 64'(out_valid), 64'd0);
        step();
        check("halt.fault", 64'(fault), 64'd1);
        check("halt.valid", 64'(out_valid), 64'd0);
        check("halt.addr", imem_addr, 64'h400);
        redirect = 1'b1; redirect_pc = 64'h0;
        step();
        check("resume.fault", 64'(fault), 64'd0);
        check("resume.valid", 64'(out_valid), 64'd0);
        redirect = 1'b0;
        step(); chk_out("resume", 64'h0);

        // misaligned redirect target
        redirect = 1'b1; redirect_pc = 64'h42;
        step();
        check("mis.redir.fault", 64'(fault), 64'd0);
        check("mis.redir.addr", imem_addr, 64'h42);
        redirect = 1'b0;
        step();
        check("mis.fault", 64'(fault), 64'd1);
        check("mis.valid", 64'(out_valid), 64'd0);
        step();
        check("mis.halt.valid", 64'(out_valid), 64'd0);
        check("mis.halt.addr", imem_addr, 64'h42);

        // reset during HALT with a redirect pending
        redirect = 1'b1; redirect_pc = 64'h80;
        reset = 1'b1;
        #1;
        check("arst.fault", 64'(fault), 64'd0);
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.addr", imem_addr, 64'h0);
        step();
        reset = 1'b0;
        step();
        check("bootredir.addr", imem_addr, 64'h0);
        check("bootredir.valid", 64'(out_valid), 64'd0);
        redirect = 1'b0;
        step(); chk_out("postrst", 64'h0);

        // aligned but far above the ROM (needs full-width compare)
        redirect = 1'b1; redirect_pc = 64'h1_0000_0000;
        step();
        redirect = 1'b0;
        step();
        check("high.fault", 64'(fault), 64'd1);
        check("high.valid", 64'(out_valid), 64'd0);

        // stall asserted, then reset mid-stall
        redirect = 1'b1; redirect_pc = 64'h20;
        step();
        redirect = 1'b0;
        out_ready = 1'b0;
        step(); chk_out("pre.rst", 64'h20);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
        end
        chk_out("cnt.seq", 64'h10);
        out_ready = 1'b0;
        step();
        step();
        chk_out("cnt.stall", 64'h10);
`ifdef IFETCH_PERF_CNT_EN
        check("fetch_count", 64'(fetch_count), 64'd5);
        check("stall_count", 64'(stall_count), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
